// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared types, constants and the nibble decoder used by the
// 7-segment display bank.
//   seg7_t      - active-low segment vector {g,f,e,d,c,b,a}
//   SEG_BLANK   - all segments off
//   SEG_ZERO    - the "0" glyph; also the reset image of every digit
//   hex_to_seg7 - 4-bit value -> seg7_t glyph (0-9, A, b, C, d, E, F)
package hex_display_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam seg7_t SEG_ZERO  = 7'b1000000;

  function automatic seg7_t hex_to_seg7(input logic [3:0] nib);
    seg7_t s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;  // F
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_display_bank_if.sv
// hex_display_bank_if: board-side bundle of the display bank.
//   din        - 4*NDIGITS display value, digit i = din[4i+3:4i] (asynchronous)
//   mode       - 0 live, 1 latched
//   load       - asynchronous level, rising edge captures din in latched mode
//   blank_lz   - suppress leading zero digits
//   blink_mask - per-digit blink enable
//   hex_o      - 7*NDIGITS active-low segments, digit i = hex_o[7i+6:7i]
//   upd_done   - one-cycle pulse when a latched capture reaches hex_o
// master drives the controls (board/CPU side), slave is the display engine.
interface hex_display_bank_if #(
  parameter int NDIGITS = 8
);
  logic [4*NDIGITS-1:0] din;
  logic                 mode;
  logic                 load;
  logic                 blank_lz;
  logic [NDIGITS-1:0]   blink_mask;
  logic [7*NDIGITS-1:0] hex_o;
  logic                 upd_done;

  modport master (
    output din, mode, load, blank_lz, blink_mask,
    input  hex_o, upd_done
  );

  modport slave (
    input  din, mode, load, blank_lz, blink_mask,
    output hex_o, upd_done
  );
endinterface

// File: rtl/hex7seg.sv
// hex7seg: purely combinational nibble -> 7-segment glyph.
//   nib_i - 4-bit digit value
//   seg_o - active-low segments {g,f,e,d,c,b,a}
module hex7seg
  import hex_display_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg7_t      seg_o
);
  assign seg_o = hex_to_seg7(nib_i);
endmodule

// File: rtl/hex_display_bank.sv
// hex_display_bank: registered N-digit hex engine for the 7-segment bank.
//   CLOCK_50 - system clock, rising edge
//   RESET_N  - asynchronous active-low reset
//   bus      - hex_display_bank_if slave: din/mode/load/blank_lz/blink_mask in,
//              hex_o/upd_done out
// Pipeline: din/load synchronisers -> value_q -> decode/blank -> hex_q.
// A din change reaches hex_o SYNC_STAGES+2 edges later in live mode.
module hex_display_bank
  import hex_display_pkg::*;
#(
  parameter int NDIGITS     = 8,
  parameter int BLINK_DIV   = 25000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic         CLOCK_50,
  input  logic         RESET_N,
  hex_display_bank_if.slave bus
);

  localparam int             DW      = 4*NDIGITS;
  localparam int             CNT_W   = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV-1);

  // synchronisers
  logic [SYNC_STAGES-1:0][DW-1:0] din_sync_q;
  logic [SYNC_STAGES-1:0]         load_sync_q;
  logic                           load_dly_q;
  logic [DW-1:0]                  din_sync;
  logic                           load_sync, load_rise, capture;

  // datapath / control state
  logic [DW-1:0]                  value_q, value_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           phase_q, phase_d, wrap;
  // vld_pipe_q[1]: capture landed in value_q; [2]: it is now on hex_o
  logic [2:1]                     vld_pipe_q;

  logic [NDIGITS-1:0][6:0]        seg_raw;
  logic [NDIGITS-1:0][6:0]        hex_q, hex_d;
  logic [NDIGITS-1:0]             lz_blank;

  assign din_sync  = din_sync_q[SYNC_STAGES-1];
  assign load_sync = load_sync_q[SYNC_STAGES-1];
  assign load_rise = load_sync & ~load_dly_q;
  // a rise seen on the same edge mode goes high still counts
  assign capture   = bus.mode & load_rise;

  always_comb begin
    value_d = value_q;
    if (!bus.mode || load_rise) value_d = din_sync;
  end

  assign wrap    = (cnt_q == CNT_MAX);
  assign cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
  assign phase_d = wrap ? ~phase_q : phase_q;

  // digit i (i>=1) is a leading zero when it and every digit above it is 0;
  // digit 0 is never flagged so a zero value still shows one "0"
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = NDIGITS-1; i >= 1; i--) begin
      zero_above  = zero_above & (value_q[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_above;
    end
  end

  for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
    hex7seg u_dec (
      .nib_i (value_q[4*g +: 4]),
      .seg_o (seg_raw[g])
    );
    assign hex_d[g] = ((bus.blank_lz & lz_blank[g]) | (phase_q & bus.blink_mask[g]))
                      ? SEG_BLANK : seg_raw[g];
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      din_sync_q  <= '0;
      load_sync_q <= '0;
      load_dly_q  <= 1'b0;
      value_q     <= '0;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      vld_pipe_q  <= '0;
      hex_q       <= {NDIGITS{SEG_ZERO}};
    end else begin
      din_sync_q[0] <= bus.din;
      for (int s = 1; s < SYNC_STAGES; s++) din_sync_q[s] <= din_sync_q[s-1];
      load_sync_q   <= {load_sync_q[SYNC_STAGES-2:0], bus.load};
      load_dly_q    <= load_sync;
      value_q       <= value_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      vld_pipe_q    <= {vld_pipe_q[1], capture};
      hex_q         <= hex_d;
    end
  end

  assign bus.hex_o    = hex_q;
  assign bus.upd_done = vld_pipe_q[2];

endmodule

// File: tb/tb_hex_display_bank.sv
module tb_hex_display_bank;
  localparam int ND = 8;

  // hand glyph table, active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011,
                         SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110,
                         SF = 7'b0001110, SX = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hex_display_bank_if #(.NDIGITS(ND)) bus();

  hex_display_bank #(.NDIGITS(ND), .BLINK_DIV(4), .SYNC_STAGES(2)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] din;
    logic        lz;
    logic [55:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [55:0] exp5, expC3, expA7;
    int upd_n, upd_at, chg_at;
    logic [6:0] prev;
    bit found;

    vecs[0] = '{32'h0000_0001, 1'b0, {S0,S0,S0,S0,S0,S0,S0,S1}, "live_01"};
    vecs[1] = '{32'h89AB_CDEF, 1'b0, {S8,S9,SA,SB,SC,SD,SE,SF}, "live_89ABCDEF"};
    vecs[2] = '{32'h0004_0000, 1'b1, {SX,SX,SX,S4,S0,S0,S0,S0}, "lz_40000"};
    vecs[3] = '{32'h0000_0000, 1'b1, {SX,SX,SX,SX,SX,SX,SX,S0}, "lz_zero"};
    vecs[4] = '{32'h0000_0000, 1'b0, {S0,S0,S0,S0,S0,S0,S0,S0}, "nolz_zero"};
    vecs[5] = '{32'h0123_4567, 1'b1, {SX,S1,S2,S3,S4,S5,S6,S7}, "lz_01234567"};
    vecs[6] = '{32'h1000_0000, 1'b1, {S1,S0,S0,S0,S0,S0,S0,S0}, "lz_top_set"};
    vecs[7] = '{32'h0000_00F0, 1'b1, {SX,SX,SX,SX,SX,SX,SF,S0}, "lz_F0"};
    exp5  = {S0,S0,S0,S0,S0,S0,S0,S5};
    expC3 = {S0,S0,S0,S0,S0,S0,SC,S3};
    expA7 = {S0,S0,S0,S0,S0,S0,SA,S7};

    bus.din = '0; bus.mode = 1'b0; bus.load = 1'b0;
    bus.blank_lz = 1'b1; bus.blink_mask = '0;

    // reset image is all "0" even with blank_lz set
    #12;
    chk("reset_hex", 64'(bus.hex_o), 64'({8{S0}}));
    chk("reset_upd", 64'(bus.upd_done), 64'd0);
    bus.blank_lz = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_reset_hex", 64'(bus.hex_o), 64'({8{S0}}));
    tick(); tick();

    // live latency: exactly SYNC_STAGES+2 = 4 edges
    bus.din = 32'h0000_0001;
    tick(); tick(); tick();
    chk("latency_edge3", 64'(bus.hex_o), 64'({8{S0}}));
    tick();
    chk("latency_edge4", 64'(bus.hex_o), 64'({S0,S0,S0,S0,S0,S0,S0,S1}));

    // table-driven live decode / leading-zero vectors
    for (int v = 0; v < 8; v++) begin
      upd_n = 0;
      bus.din = vecs[v].din;
      bus.blank_lz = vecs[v].lz;
      for (int k = 0; k < 5; k++) begin
        tick();
        if (bus.upd_done) upd_n++;
      end
      chk(vecs[v].name, 64'(bus.hex_o), 64'(vecs[v].exp));
      chk({vecs[v].name, "_upd"}, 64'(upd_n), 64'd0);
    end
    bus.blank_lz = 1'b0;

    // latched mode: hold, then a 3-cycle load pulse
    bus.din = 32'h0000_0005;
    repeat (5) tick();
    chk("live_5", 64'(bus.hex_o), 64'(exp5));
    bus.mode = 1'b1;
    bus.din = 32'h0000_00C3;
    upd_n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("latched_hold", 64'(bus.hex_o), 64'(exp5));
      if (bus.upd_done) upd_n++;
    end
    chk("latched_hold_upd", 64'(upd_n), 64'd0);

    bus.load = 1'b1;
    upd_n = 0; upd_at = -1; chg_at = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.upd_done) begin upd_n++; upd_at = k; end
      if (chg_at < 0 && bus.hex_o == expC3) chg_at = k;
      if (k == 3) bus.load = 1'b0;
    end
    chk("cap_hex_edge", 64'(chg_at), 64'd4);
    chk("cap_upd_edge", 64'(upd_at), 64'd4);
    chk("cap_upd_count", 64'(upd_n), 64'd1);
    chk("cap_hex", 64'(bus.hex_o), 64'(expC3));

    // held-high load captures once
    bus.din = 32'h0000_00A7;
    tick(); tick(); tick();
    chk("held_pre", 64'(bus.hex_o), 64'(expC3));
    bus.load = 1'b1;
    upd_n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.upd_done) upd_n++;
    end
    bus.load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.upd_done) upd_n++;
    end
    chk("held_upd_count", 64'(upd_n), 64'd1);
    chk("held_hex", 64'(bus.hex_o), 64'(expA7));

    // 1->0 resumes tracking on the next edge
    bus.din = 32'h0000_0003;
    repeat (4) tick();
    chk("frozen", 64'(bus.hex_o), 64'(expA7));
    bus.mode = 1'b0;
    tick();
    chk("resume_edge1", 64'(bus.hex_o), 64'(expA7));
    tick();
    chk("resume_edge2", 64'(bus.hex_o), 64'({S0,S0,S0,S0,S0,S0,S0,S3}));

    // load rise arriving on the same edge mode goes high still captures
    bus.load = 1'b1;
    tick(); tick();
    bus.mode = 1'b1;
    upd_n = 0; upd_at = -1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (bus.upd_done) begin upd_n++; upd_at = k; end
    end
    chk("same_cycle_upd_count", 64'(upd_n), 64'd1);
    chk("same_cycle_upd_edge", 64'(upd_at), 64'd2);
    bus.load = 1'b0;

    // blink: digit0 alternates 4 on / 4 off, digit1 steady
    bus.mode = 1'b0;
    bus.din = 32'h0000_0002;
    bus.blink_mask = 8'h01;
    found = 1'b0;
    prev = bus.hex_o[6:0];
    for (int k = 0; k < 30; k++) begin
      tick();
      if (prev == S2 && bus.hex_o[6:0] == SX) begin found = 1'b1; break; end
      prev = bus.hex_o[6:0];
    end
    chk("blink_found", 64'(found), 64'd1);
    for (int j = 1; j <= 16; j++) begin
      tick();
      chk("blink_d0", 64'(bus.hex_o[6:0]), 64'(((j % 8) < 4) ? SX : S2));
      chk("blink_d1", 64'(bus.hex_o[13:7]), 64'(S0));
    end

    // reset in the middle of a latched capture
    bus.mode = 1'b1;
    bus.din = 32'h0000_0009;
    tick(); tick();
    bus.load = 1'b1;
    tick(); tick(); tick();   // capture has just landed in value_q
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_hex", 64'(bus.hex_o), 64'({8{S0}}));
    chk("async_reset_upd", 64'(bus.upd_done), 64'd0);
    bus.load = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    upd_n = 0;
    // phase flips on the 4th edge after release, visible on hex_o at the 5th
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.upd_done) upd_n++;
      chk("rst_blink_d0", 64'(bus.hex_o[6:0]), 64'((k <= 4) ? S0 : SX));
      chk("rst_upper", 64'(bus.hex_o[55:7]), 64'({7{S0}}));
    end
    chk("rst_no_upd", 64'(upd_n), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
